dmem_pipelined: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with a valid/ready request port, a configurable-latency in-order response pipeline, response backpressure, byte/half/word access with sign/zero extension, and fault reporting.
- Sits in the MEM stage, between the LSU address/data path and writeback.

---
 rtl/dmem_pipelined_pkg.sv | 24 ++
 rtl/dmem_resp_pipe.sv | 74 +++++++
 rtl/dmem_pipelined.sv | 128 ++++++++++++
 tb/tb_dmem_pipelined.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pipelined_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_pipelined_pkg : shared constants for the pipelined data memory        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dmem_pipelined_pkg;

    localparam int DEF_ADDR_SIZE = 32;
    localparam int DEF_WORD_LEN  = 32;
    localparam int NUM_LANES     = 4;

    localparam logic [2:0] FUNCT3_BYTE          = 3'b000;
    localparam logic [2:0] FUNCT3_HALF          = 3'b001;
    localparam logic [2:0] FUNCT3_WORD          = 3'b010;
    localparam logic [2:0] FUNCT3_BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] FUNCT3_HALF_UNSIGNED = 3'b101;

    function automatic logic funct3_is_legal(input logic [2:0] f3);
        return (f3 == FUNCT3_BYTE) || (f3 == FUNCT3_HALF) || (f3 == FUNCT3_WORD) ||
               (f3 == FUNCT3_BYTE_UNSIGNED) || (f3 == FUNCT3_HALF_UNSIGNED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_resp_pipe : READ_LAT-deep response shift register, frozen on stall    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_resp_pipe #(
    parameter int READ_LAT  = 1,
    parameter int WORD_LEN  = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [WORD_LEN-1:0]  in_rdata,
    input  logic                 in_fault,
    input  logic [ADDR_SIZE-1:0] in_pc,
    output logic                 out_valid,
    output logic [WORD_LEN-1:0]  out_rdata,
    output logic                 out_fault,
    output logic [ADDR_SIZE-1:0] out_pc
);

    logic                 valid_q [READ_LAT];
    logic                 valid_d [READ_LAT];
    logic                 fault_q [READ_LAT];
    logic                 fault_d [READ_LAT];
    logic [WORD_LEN-1:0]  rdata_q [READ_LAT];
    logic [WORD_LEN-1:0]  rdata_d [READ_LAT];
    logic [ADDR_SIZE-1:0] pc_q    [READ_LAT];
    logic [ADDR_SIZE-1:0] pc_d    [READ_LAT];

    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        pc_d    = pc_q;
        if (en) begin
            valid_d[0] = in_valid;
            fault_d[0] = in_fault;
            rdata_d[0] = in_rdata;
            pc_d[0]    = in_pc;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                fault_d[i] = fault_q[i-1];
                rdata_d[i] = rdata_q[i-1];
                pc_d[i]    = pc_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                valid_q[i] <= 1'b0;
                fault_q[i] <= 1'b0;
                rdata_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q[READ_LAT-1];
    assign out_fault = fault_q[READ_LAT-1];
    assign out_rdata = rdata_q[READ_LAT-1];
    assign out_pc    = pc_q[READ_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dmem_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_pipelined : byte-lane data RAM with in-order, stallable response pipe |
// | Optional macro DMEM_FAULT_EN enables fault detection (else legacy wrap).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_pipelined
    import dmem_pipelined_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int WORD_LEN   = DEF_WORD_LEN,
    parameter int DMEM_DEPTH = 1024,
    parameter int READ_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [2:0]           req_funct3,
    input  logic [WORD_LEN-1:0]  req_wdata,
    input  logic [ADDR_SIZE-1:0] req_pc,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_LEN-1:0]  resp_rdata,
    output logic                 resp_fault,
    output logic [ADDR_SIZE-1:0] resp_pc
);

    localparam int IDX_W = $clog2(DMEM_DEPTH);
`ifdef DMEM_FAULT_EN
    localparam logic [ADDR_SIZE:0] MEM_BYTES = (ADDR_SIZE+1)'(4 * DMEM_DEPTH);
`endif

    logic                 stall;
    logic                 accept;
    logic [IDX_W-1:0]     idx;
    logic [1:0]           offset;
    logic                 is_byte;
    logic                 is_half;
    logic                 is_unsigned;
    logic                 fault;
    logic [NUM_LANES-1:0] byte_en;
    logic [WORD_LEN-1:0]  lane_wdata;
    logic [WORD_LEN-1:0]  rd_word;
    logic [WORD_LEN-1:0]  rd_shift;
    logic [WORD_LEN-1:0]  load_data;
    logic                 unused_addr;

    assign stall       = resp_valid && !resp_ready;
    assign req_ready   = rst_n && !stall;
    assign accept      = req_valid && req_ready;
    assign idx         = req_addr[IDX_W+1:2];
    assign unused_addr = ^req_addr;

    // Misaligned halves/words align down; with faults enabled they never write or return data.
    always_comb begin
        is_byte     = (req_funct3 == FUNCT3_BYTE) || (req_funct3 == FUNCT3_BYTE_UNSIGNED);
        is_half     = (req_funct3 == FUNCT3_HALF) || (req_funct3 == FUNCT3_HALF_UNSIGNED);
        is_unsigned = req_funct3[2];
        if (is_byte)      offset = req_addr[1:0];
        else if (is_half) offset = {req_addr[1], 1'b0};
        else              offset = 2'b00;
`ifdef DMEM_FAULT_EN
        fault = !funct3_is_legal(req_funct3)
             || (is_half && req_addr[0])
             || (!is_byte && !is_half && (req_addr[1:0] != 2'b00))
             || ({1'b0, req_addr} >= MEM_BYTES);
`else
        fault = 1'b0;
`endif
    end

    always_comb begin
        if (is_byte) begin
            byte_en    = 4'b0001 << offset;
            lane_wdata = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            byte_en    = 4'b0011 << offset;
            lane_wdata = {2{req_wdata[15:0]}};
        end else begin
            byte_en    = '1;
            lane_wdata = req_wdata;
        end
    end

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            logic [7:0] mem [DMEM_DEPTH];
            always_ff @(posedge clk) begin
                if (accept && req_write && !fault && byte_en[l]) begin
                    mem[idx] <= lane_wdata[8*l +: 8];
                end
            end
            assign rd_word[8*l +: 8] = mem[idx];
        end
    endgenerate

    // Idle slots carry zeros so the response bus is quiet between transfers.
    always_comb begin
        rd_shift = rd_word >> {offset, 3'b000};
        if (is_byte)      load_data = {{24{!is_unsigned && rd_shift[7]}}, rd_shift[7:0]};
        else if (is_half) load_data = {{16{!is_unsigned && rd_shift[15]}}, rd_shift[15:0]};
        else              load_data = rd_shift;
        if (!accept || req_write || fault) load_data = '0;
    end

    dmem_resp_pipe #(
        .READ_LAT  (READ_LAT),
        .WORD_LEN  (WORD_LEN),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (!stall),
        .in_valid  (accept),
        .in_rdata  (load_data),
        .in_fault  (accept && fault),
        .in_pc     (accept ? req_pc : '0),
        .out_valid (resp_valid),
        .out_rdata (resp_rdata),
        .out_fault (resp_fault),
        .out_pc    (resp_pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_pipelined : scoreboard bench with byte-array reference model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_pipelined;

    localparam int READ_LAT = 2;
    localparam int DEPTH    = 1024;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] resp_pc;

    always #5 clk = ~clk;

    dmem_pipelined #(
        .ADDR_SIZE  (32),
        .WORD_LEN   (32),
        .DMEM_DEPTH (DEPTH),
        .READ_LAT   (READ_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .resp_pc    (resp_pc)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] pc;
        int          cnt;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] ref_mem [4*DEPTH];
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 0;
    bit         zero_chk = 0;
    bit         rand_done = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference model: memory as a flat byte array, accesses by size/alignment arithmetic.
    function automatic exp_t ref_access(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [31:0] pc);
        exp_t        e;
        int          size;
        bit          uns;
        bit          flt;
        logic [31:0] a;
        logic [31:0] v;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        uns  = (f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_FAULT_EN
        flt = (f3 == 3'd3) || (f3 >= 3'd6) || ((addr % size) != 0) || (addr >= 4*DEPTH);
        a   = addr;
`else
        flt = 0;
        a   = addr % (4*DEPTH);
        a   = a - (a % size);
`endif
        v = '0;
        if (!flt) begin
            for (int i = 0; i < size; i++) begin
                if (wr) ref_mem[a+i] = wdata[8*i +: 8];
                else    v = v | (32'(ref_mem[a+i]) << (8*i));
            end
        end
        if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        e.rdata = (wr || flt) ? 32'h0 : v;
        e.fault = flt;
        e.pc    = pc;
        e.cnt   = READ_LAT - 1;
        return e;
    endfunction

    // Monitor: checks at each negedge, then advances the model to the next posedge.
    always @(negedge clk) begin
        bit mv;
        bit stall;
        mv = (sbq.size() > 0) && (sbq[0].cnt == 0);
        if (chk_en) begin
            check("resp_valid", 32'(resp_valid), 32'(mv));
            check("req_ready", 32'(req_ready), 32'(rst_n && !(mv && !resp_ready)));
            if (mv) begin
                check("resp_rdata", resp_rdata, sbq[0].rdata);
                check("resp_fault", 32'(resp_fault), 32'(sbq[0].fault));
                check("resp_pc", resp_pc, sbq[0].pc);
            end
            if (zero_chk) begin
                check("reset_rdata", resp_rdata, 32'h0);
                check("reset_fault", 32'(resp_fault), 32'h0);
                check("reset_pc", resp_pc, 32'h0);
            end
        end
        stall = mv && !resp_ready;
        if (!rst_n) begin
            sbq.delete();
            chk_en   = 1;
            zero_chk = 1;
        end else begin
            zero_chk = 0;
            if (!stall) begin
                if (mv) void'(sbq.pop_front());
                foreach (sbq[i]) if (sbq[i].cnt > 0) sbq[i].cnt = sbq[i].cnt - 1;
                if (req_valid) sbq.push_back(ref_access(req_write, req_funct3, req_addr, req_wdata, req_pc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        done       = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = $urandom;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout: got no accept, expected accept within 100 cycles");
        end
        req_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);
        for (int w = 0; w < 64; w++) issue(1'b1, F_W, 32'(w*4), $urandom);

        issue(1'b1, F_W,  32'h10, 32'hDEAD_BEEF);
        issue(1'b0, F_W,  32'h10, 32'h0);
        issue(1'b0, F_B,  32'h13, 32'h0);
        issue(1'b0, F_BU, 32'h13, 32'h0);
        issue(1'b0, F_H,  32'h12, 32'h0);
        issue(1'b0, F_HU, 32'h10, 32'h0);
        issue(1'b1, F_B,  32'h11, 32'h0000_0055);
        issue(1'b0, F_W,  32'h10, 32'h0);
        issue(1'b0, F_W,  32'h12, 32'h0);
        issue(1'b1, F_H,  32'h11, 32'h0000_1234);
        issue(1'b0, F_W,  32'h10, 32'h0);
        issue(1'b0, F_W,  32'h1000, 32'h0);
        issue(1'b1, F_W,  32'h1004, 32'hCAFE_F00D);
        issue(1'b0, F_W,  32'h04, 32'h0);
        issue(1'b0, 3'b011, 32'h20, 32'h0);
        issue(1'b0, 3'b110, 32'h20, 32'h0);
        issue(1'b1, 3'b111, 32'h24, 32'h1111_2222);
        issue(1'b0, F_W,  32'h24, 32'h0);
        idle(5);

        resp_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) issue(1'b0, F_W, 32'(32'h40 + 4*k), 32'h0);
            end
            begin
                idle(5);
                resp_ready = 1'b1;
            end
        join
        idle(5);

        rand_done = 0;
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    logic [31:0] a;
                    a = $urandom % 256;
                    if ($urandom % 8 == 0) a = a + 32'h1000 * (1 + $urandom % 3);
                    if ($urandom % 4 == 0) idle(1);
                    issue(($urandom % 3) == 0, 3'($urandom % 8), a, $urandom);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    resp_ready = ($urandom % 4) != 0;
                    idle(1);
                end
                resp_ready = 1'b1;
            end
        join
        idle(5);

        issue(1'b0, F_W, 32'h10, 32'h0);
        issue(1'b0, F_W, 32'h14, 32'h0);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(10);

        for (int n = 0; n < 100 && sbq.size() > 0; n++) idle(1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
